// File: rtl/tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tinyalu_arbiter
//
// Shares one TinyALU among NUM_REQ requesters. A round-robin arbiter accepts one
// request at a time on a valid/ready port. A three-state sequencer
// (IDLE -> WAIT -> RESP) drives the ALU start/done protocol and returns the
// 16-bit result on a one-hot response strobe.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   TIMEOUT      WAIT cycles allowed before an operation is aborted (1..255)
//
// Ports
//   clk_i        system clock, rising edge
//   reset_n_i    asynchronous active-low reset
//   req_valid_i  per-requester request pending
//   req_ready_o  per-requester accept strobe (one-hot or zero, IDLE only)
//   req_a_i      operand A, byte slice i belongs to requester i
//   req_b_i      operand B, byte slice i
//   req_op_i     opcode, 3-bit slice i (000 nop, 001 add, 010 and,
//                011 xor, 100 mul, 101..111 illegal)
//   rsp_valid_o  one-cycle one-hot response strobe
//   rsp_result_o response data, meaningful while rsp_valid_o is non-zero
//   rsp_error_o  response is an error (illegal opcode or timeout)
//   alu_a_o      ALU operand A (registered)
//   alu_b_o      ALU operand B (registered)
//   alu_op_o     ALU opcode (registered)
//   alu_start_o  ALU start (registered)
//   alu_done_i   ALU completion pulse, only looked at in WAIT
//   alu_result_i ALU result, captured together with alu_done_i
// -----------------------------------------------------------------------------
module tinyalu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [8*NUM_REQ-1:0] req_a_i,
  input  logic [8*NUM_REQ-1:0] req_b_i,
  input  logic [3*NUM_REQ-1:0] req_op_i,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [15:0]          rsp_result_o,
  output logic                 rsp_error_o,
  output logic [7:0]           alu_a_o,
  output logic [7:0]           alu_b_o,
  output logic [2:0]           alu_op_o,
  output logic                 alu_start_o,
  input  logic                 alu_done_i,
  input  logic [15:0]          alu_result_i
);

  localparam int         PTR_W  = $clog2(NUM_REQ);
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [NUM_REQ-1:0] gnt_q;        // one-hot owner of the operation in flight
  logic [7:0]         cnt_q;        // WAIT cycles elapsed
  logic [7:0]         alu_a_q;
  logic [7:0]         alu_b_q;
  logic [2:0]         alu_op_q;
  logic               alu_start_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [15:0]        rsp_result_q;
  logic               rsp_error_q;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration.
  // Requests at index >= ptr are preferred; if none exist the search wraps to
  // the full request vector. The lowest set bit of the chosen vector wins,
  // which is exactly "first set bit at or after ptr, wrapping to 0".
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic [NUM_REQ-1:0] pick_src;
  logic [NUM_REQ-1:0] gnt_oh;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign upper_mask[gi] = (PTR_W'(gi) >= ptr_q);
    end
  endgenerate

  assign upper_req = req_valid_i & upper_mask;
  assign pick_src  = (|upper_req) ? upper_req : req_valid_i;
  // Two's-complement trick isolates the lowest set bit.
  assign gnt_oh    = pick_src & (~pick_src + NUM_REQ'(1));

  // Operand mux and winner index, driven by the one-hot grant.
  logic [PTR_W-1:0] gnt_idx;
  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic [2:0]       sel_op;

  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        gnt_idx = PTR_W'(i);
        sel_a   = req_a_i[8*i +: 8];
        sel_b   = req_b_i[8*i +: 8];
        sel_op  = req_op_i[3*i +: 3];
      end
    end
  end

  logic [PTR_W-1:0] ptr_d;
  logic             handshake;
  logic             op_legal;

  assign ptr_d     = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  assign handshake = (state_q == ST_IDLE) && (|req_valid_i);
  assign op_legal  = (sel_op <= OP_MUL);

  // ready is gated by reset_n_i directly so it drops the moment reset asserts.
  assign req_ready_o = ((state_q == ST_IDLE) && reset_n_i) ? gnt_oh : '0;

  // ---------------------------------------------------------------------------
  // Timeout: cnt_d is the number of WAIT cycles including the current one.
  // ---------------------------------------------------------------------------
  logic [7:0] cnt_d;
  logic       timeout_hit;

  assign cnt_d       = cnt_q + 8'd1;
  assign timeout_hit = (cnt_d == TO_VAL);

  // ---------------------------------------------------------------------------
  // Sequencer with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_NOP;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            gnt_q <= gnt_oh;
            ptr_q <= ptr_d;
            cnt_q <= '0;
            if (op_legal) begin
              alu_a_q     <= sel_a;
              alu_b_q     <= sel_b;
              alu_op_q    <= sel_op;
              alu_start_q <= 1'b1;
              state_q     <= ST_WAIT;
            end else begin
              // Illegal opcode: answer immediately, ALU pins stay untouched.
              rsp_valid_q  <= gnt_oh;
              rsp_result_q <= '0;
              rsp_error_q  <= 1'b1;
              state_q      <= ST_RESP;
            end
          end
        end

        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (alu_op_q == OP_NOP) begin
            // no_op: exactly one start cycle, done is not awaited.
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= gnt_q;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            state_q      <= ST_RESP;
          end else if (alu_done_i) begin
            // done wins over a timeout landing in the same cycle.
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= gnt_q;
            rsp_result_q <= alu_result_i;
            rsp_error_q  <= 1'b0;
            state_q      <= ST_RESP;
          end else if (timeout_hit) begin
            alu_start_q  <= 1'b0;
            rsp_valid_q  <= gnt_q;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            state_q      <= ST_RESP;
          end
        end

        ST_RESP: begin
          // Response strobe lasts one cycle; no backpressure.
          rsp_valid_q  <= '0;
          rsp_result_q <= '0;
          rsp_error_q  <= 1'b0;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign alu_start_o  = alu_start_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_error_o  = rsp_error_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tinyalu_arbiter
//
// Drives requesters and a latency-configurable ALU model, and predicts every
// cycle of req_ready, rsp_valid/result/error and alu_start/a/b/op from a
// transaction-level reference model (round-robin pointer plus per-operation
// response schedule). Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_tinyalu_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [3*N-1:0] req_op;
  logic [N-1:0]   rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_error;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [2:0]     alu_op;
  logic           alu_start;
  logic           alu_done;
  logic [15:0]    alu_result;

  always #5 clk = ~clk;

  tinyalu_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_op_i     (req_op),
    .rsp_valid_o  (rsp_valid),
    .rsp_result_o (rsp_result),
    .rsp_error_o  (rsp_error),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_start_o  (alu_start),
    .alu_done_i   (alu_done),
    .alu_result_i (alu_result)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Stimulus state
  logic [N-1:0] post_v;
  logic [7:0]   post_a  [N];
  logic [7:0]   post_b  [N];
  logic [2:0]   post_op [N];
  int  hs_last, sticky_left, alu_lat, st_cnt;
  bit  noise, rand_mode, release_req, in_reset;

  // Reference model state
  int mptr, free_at, rsp_at, rsp_idx, st_from, st_to;
  logic [7:0]  ea, eb;
  logic [2:0]  eop;
  logic [15:0] exp_res;
  logic        exp_err;

  // Observations of the DUT for directed checks
  int          grant_log[$];
  logic [15:0] res_log[$];
  int          last_hs_cyc, last_rsp_cyc, last_idx, start_cycles, low_run, min_gap;
  bit          seen_start, prev_start;
  logic [15:0] last_res;
  logic        last_err;
  logic [N-1:0] rsp_mask;

  function automatic logic [15:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic post(int i, logic [7:0] a, logic [7:0] b, logic [2:0] op);
    post_v[i]  = 1'b1;
    post_a[i]  = a;
    post_b[i]  = b;
    post_op[i] = op;
  endtask

  task automatic drive_inputs();
    if (release_req) begin
      reset_n     = 1'b1;
      in_reset    = 1'b0;
      release_req = 1'b0;
    end
    if (hs_last >= 0) begin
      if (sticky_left > 0) sticky_left--;
      else req_valid[hs_last] = 1'b0;
      hs_last = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (post_v[i]) begin
        req_valid[i]      = 1'b1;
        req_a[8*i +: 8]   = post_a[i];
        req_b[8*i +: 8]   = post_b[i];
        req_op[3*i +: 3]  = post_op[i];
        post_v[i]         = 1'b0;
      end
    end
    if (rand_mode) begin
      if (cyc >= free_at && $urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0:       alu_lat = 0;
          1:       alu_lat = TO;
          2:       alu_lat = TO + 1;
          default: alu_lat = $urandom_range(1, 4);
        endcase
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 99) < 30) begin
          int r;
          r = $urandom_range(0, 9);
          req_valid[i]     = 1'b1;
          req_a[8*i +: 8]  = 8'($urandom);
          req_b[8*i +: 8]  = 8'($urandom);
          req_op[3*i +: 3] = (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
        end
      end
    end
    // ALU model: done in the alu_lat-th cycle of start (0 = never).
    if (alu_start) begin
      st_cnt++;
      if (alu_lat != 0 && st_cnt == alu_lat) begin
        alu_done   = 1'b1;
        alu_result = (alu_op == 3'b000) ? 16'($urandom) : ref_alu(alu_a, alu_b, alu_op);
      end else begin
        alu_done   = 1'b0;
        alu_result = 16'($urandom);
      end
    end else begin
      st_cnt     = 0;
      alu_done   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      alu_result = 16'($urandom);
    end
  endtask

  task automatic observe_and_check();
    int w;
    logic [N-1:0] exp_ready, exp_rsp;
    bit exp_start;
    // Observation logs
    if (alu_start) begin
      start_cycles++;
      if (!prev_start && seen_start && low_run < min_gap) min_gap = low_run;
      seen_start = 1'b1;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_start = alu_start;
    if (req_ready != '0) begin
      grant_log.push_back(onehot_idx(req_ready));
      last_hs_cyc = cyc;
    end
    if (rsp_valid != '0) begin
      last_rsp_cyc = cyc;
      last_res     = rsp_result;
      last_err     = rsp_error;
      last_idx     = onehot_idx(rsp_valid);
      rsp_mask     = rsp_mask | rsp_valid;
      res_log.push_back(rsp_result);
    end
    // Reference model: first valid requester at or after the pointer wins.
    w = -1;
    if (!in_reset && cyc >= free_at) begin
      for (int i = 0; i < N; i++) begin
        if (w < 0 && req_valid[(mptr + i) % N]) w = (mptr + i) % N;
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("ready", req_ready, exp_ready);
    exp_rsp = '0;
    if (cyc == rsp_at) exp_rsp[rsp_idx] = 1'b1;
    check("rsp_valid", rsp_valid, exp_rsp);
    if (cyc == rsp_at) begin
      check("rsp_result", rsp_result, exp_res);
      check("rsp_error", rsp_error, exp_err);
      $display("txn req %0d op %0d a %02h b %02h result %04h error %0d cycle %0d",
               rsp_idx, eop, ea, eb, rsp_result, rsp_error, cyc);
    end
    exp_start = (cyc >= st_from && cyc <= st_to);
    check("alu_start", alu_start, exp_start);
    if (exp_start) begin
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
      check("alu_op", alu_op, eop);
    end
    if (w >= 0) begin
      mptr    = (w + 1) % N;
      hs_last = w;
      ea      = req_a[8*w +: 8];
      eb      = req_b[8*w +: 8];
      eop     = req_op[3*w +: 3];
      rsp_idx = w;
      if (eop > 3'd4) begin
        st_from = 0; st_to = -1;
        rsp_at = cyc + 1; exp_res = 16'h0; exp_err = 1'b1;
      end else if (eop == 3'd0) begin
        st_from = cyc + 1; st_to = cyc + 1;
        rsp_at = cyc + 2; exp_res = 16'h0; exp_err = 1'b0;
      end else if (alu_lat >= 1 && alu_lat <= TO) begin
        st_from = cyc + 1; st_to = cyc + alu_lat;
        rsp_at = cyc + alu_lat + 1; exp_res = ref_alu(ea, eb, eop); exp_err = 1'b0;
      end else begin
        st_from = cyc + 1; st_to = cyc + TO;
        rsp_at = cyc + TO + 1; exp_res = 16'h0; exp_err = 1'b1;
      end
      free_at = rsp_at + 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
    #1;
    observe_and_check();
  endtask

  function automatic bit idle();
    return !in_reset && cyc >= free_at && req_valid == '0 && post_v == '0;
  endfunction

  task automatic drain(string tag, int budget);
    int n = 0;
    while (!idle() && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 32'(idle()), 1);
  endtask

  task automatic check_reset_zero(string tag);
    check({tag, "_ready"},  req_ready, '0);
    check({tag, "_start"},  alu_start, 1'b0);
    check({tag, "_a"},      alu_a, 8'h00);
    check({tag, "_b"},      alu_b, 8'h00);
    check({tag, "_op"},     alu_op, 3'b000);
    check({tag, "_rspv"},   rsp_valid, '0);
    check({tag, "_rspres"}, rsp_result, 16'h0000);
    check({tag, "_rsperr"}, rsp_error, 1'b0);
  endtask

  // Assert reset mid-cycle, check outputs asynchronously, release after a
  // couple of cycles (release lands right after a rising edge).
  task automatic do_reset(string tag);
    #3;
    reset_n  = 1'b0;
    in_reset = 1'b1;
    mptr = 0; rsp_at = -1; st_from = 0; st_to = -1; free_at = 0; hs_last = -1;
    grant_log.delete();
    res_log.delete();
    rsp_mask = '0;
    #1;
    check_reset_zero(tag);
    step();
    step();
    release_req = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; in_reset = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    alu_done = 1'b0; alu_result = '0;
    post_v = '0; hs_last = -1; sticky_left = 0; alu_lat = 1; st_cnt = 0;
    noise = 1'b0; rand_mode = 1'b0; release_req = 1'b0;
    mptr = 0; free_at = 0; rsp_at = -1; rsp_idx = 0; st_from = 0; st_to = -1;
    ea = '0; eb = '0; eop = '0; exp_res = '0; exp_err = 1'b0;
    last_hs_cyc = 0; last_rsp_cyc = 0; last_idx = -1; last_res = '0; last_err = 1'b0;
    start_cycles = 0; low_run = 0; min_gap = 1000; seen_start = 1'b0; prev_start = 1'b0;
    rsp_mask = '0;

    // Reset values, with every requester asking to prove ready is held off.
    repeat (2) @(posedge clk);
    req_valid = '1;
    #3;
    check_reset_zero("rst0");
    req_valid = '0;
    release_req = 1'b1;
    step();

    // Single add on requester 2, done in the first start cycle.
    alu_lat = 1; start_cycles = 0;
    post(2, 8'hFF, 8'h01, 3'b001);
    drain("t1", 40);
    check("t1_res", last_res, 16'h0100);
    check("t1_err", last_err, 1'b0);
    check("t1_idx", last_idx, 2);
    check("t1_lat", last_rsp_cyc - last_hs_cyc, 2);
    check("t1_starts", start_cycles, 1);

    // All four continuously valid with mul; pointer back at 0 after reset.
    do_reset("rst1");
    alu_lat = 2; sticky_left = 1; min_gap = 1000; seen_start = 1'b0;
    for (int i = 0; i < N; i++) post(i, 8'(i + 3), 8'd10, 3'b100);
    drain("t3", 200);
    check("t3_ngrant", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      check("t3_grant", (grant_log.size() > i) ? grant_log[i] : 99, i % N);
    for (int i = 0; i < 4; i++)
      check("t3_result", (res_log.size() > i) ? res_log[i] : 16'hDEAD, 16'((i + 3) * 10));
    check("t3_gap", 32'(min_gap >= 2), 1);

    // Illegal opcode on requester 1.
    start_cycles = 0;
    post(1, 8'h5A, 8'hA5, 3'b111);
    drain("t4", 40);
    check("t4_lat", last_rsp_cyc - last_hs_cyc, 1);
    check("t4_idx", last_idx, 1);
    check("t4_err", last_err, 1'b1);
    check("t4_res", last_res, 16'h0000);
    check("t4_starts", start_cycles, 0);

    // no_op on requester 3 with a noisy alu_done.
    noise = 1'b1; start_cycles = 0;
    post(3, 8'h12, 8'h34, 3'b000);
    drain("t5", 40);
    check("t5_lat", last_rsp_cyc - last_hs_cyc, 2);
    check("t5_idx", last_idx, 3);
    check("t5_res", last_res, 16'h0000);
    check("t5_err", last_err, 1'b0);
    check("t5_starts", start_cycles, 1);

    // Timeout: ALU never completes; then a normal add must still go through.
    noise = 1'b0; alu_lat = 0; start_cycles = 0;
    post(0, 8'h07, 8'h06, 3'b100);
    drain("t6", 60);
    check("t6_lat", last_rsp_cyc - last_hs_cyc, TO + 1);
    check("t6_starts", start_cycles, TO);
    check("t6_err", last_err, 1'b1);
    check("t6_res", last_res, 16'h0000);
    alu_lat = 1;
    post(1, 8'h20, 8'h22, 3'b001);
    drain("t6b", 40);
    check("t6b_idx", last_idx, 1);
    check("t6b_err", last_err, 1'b0);
    check("t6b_res", last_res, 16'h0042);

    // Reset while a mul on requester 2 is waiting; 0 and 3 are queued.
    alu_lat = 0;
    post(2, 8'h07, 8'h09, 3'b100);
    repeat (4) step();
    post(0, 8'h01, 8'h02, 3'b001);
    post(3, 8'h03, 8'h04, 3'b001);
    step();
    alu_lat = 1;
    do_reset("rst2");
    drain("t7", 60);
    check("t7_first", (grant_log.size() > 0) ? grant_log[0] : 99, 0);
    check("t7_norsp2", rsp_mask[2], 1'b0);
    check("t7_nrsp", res_log.size(), 2);

    // Randomized traffic with random ALU latencies and stray done pulses.
    noise = 1'b1; rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    drain("rand", 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
